// File: rtl/pipe_pkg.sv
// Shared constants for the execute-to-memory pipeline register.
// Control bundle bit map and slot occupancy encodings.
package pipe_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REG_ADDR_WIDTH_DEF = 5;
   localparam int CTRL_WIDTH_DEF     = 5;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_RESULTSRC = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_MUXJUMP   = 3;
   localparam int CTRL_JUMPRT    = 4;

   // {main_valid, skid_valid}
   localparam logic [1:0] OCC_EMPTY = 2'b00;
   localparam logic [1:0] OCC_ONE   = 2'b10;
   localparam logic [1:0] OCC_TWO   = 2'b11;

   function automatic int payload_width(int dw, int rw, int cw);
      return 4 * dw + rw + cw;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a valid bit.
// Clear wins over load; clearing leaves the stored data untouched.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/exmem_pipe_stage.sv
// Execute-to-memory pipeline register with valid/ready handshake,
// synchronous flush and an optional skid slot for a registered in_ready.
module exmem_pipe_stage
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int CTRL_WIDTH     = CTRL_WIDTH_DEF,
   parameter bit SKID_EN        = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     alu_result_e,
   input  logic [DATA_WIDTH-1:0]     write_data_e,
   input  logic [REG_ADDR_WIDTH-1:0] rd_e,
   input  logic [DATA_WIDTH-1:0]     pc_target_e,
   input  logic [DATA_WIDTH-1:0]     pc_plus4_e,
   input  logic [CTRL_WIDTH-1:0]     ctrl_e,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     alu_result_m,
   output logic [DATA_WIDTH-1:0]     write_data_m,
   output logic [REG_ADDR_WIDTH-1:0] rd_m,
   output logic [DATA_WIDTH-1:0]     pc_target_m,
   output logic [DATA_WIDTH-1:0]     pc_plus4_m,
   output logic [CTRL_WIDTH-1:0]     ctrl_m
);

   localparam int PW =
      payload_width(DATA_WIDTH, REG_ADDR_WIDTH, CTRL_WIDTH);

   logic [PW-1:0]         in_payload;
   logic [PW-1:0]         main_d;
   logic [PW-1:0]         main_q;
   logic [PW-1:0]         skid_q;
   logic                  main_valid;
   logic                  skid_valid;
   logic                  main_load;
   logic                  main_clear;
   logic                  skid_load;
   logic                  skid_clear;
   logic                  accept;
   logic                  pop;
   logic [1:0]            occ;
   logic [CTRL_WIDTH-1:0] main_ctrl;

   assign in_payload = {alu_result_e, write_data_e, rd_e,
                        pc_target_e, pc_plus4_e, ctrl_e};

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;
   assign occ    = {main_valid, skid_valid};

   // Without a skid slot, ONE never sees accept without pop,
   // so the same next-state logic serves both variants.
   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_payload;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         unique case (occ)
            OCC_EMPTY: main_load = accept;
            OCC_ONE: begin
               main_load  = accept & pop;
               skid_load  = accept & ~pop;
               main_clear = pop & ~accept;
            end
            OCC_TWO: begin
               if (pop) begin
                  main_load  = 1'b1;
                  main_d     = skid_q;
                  skid_clear = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   pipe_slot #(.W(PW)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipe_slot #(.W(PW)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_payload),
            .valid (skid_valid),
            .q     (skid_q)
         );
         assign in_ready = ~skid_valid;
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_q     = '0;
         assign in_ready   = ~main_valid | out_ready;
      end
   endgenerate

   assign out_valid = main_valid;

   assign {alu_result_m, write_data_m, rd_m,
           pc_target_m, pc_plus4_m, main_ctrl} = main_q;

   assign ctrl_m = main_valid ? main_ctrl : '0;

endmodule
